// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide, byte-addressed, big-endian data memory.
// Optional STAT_COUNT_EN macro adds ld_cnt/st_cnt completion counters.
module mem_access_unit #(
   parameter int unsigned ADDR_LIMIT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
`ifdef STAT_COUNT_EN
   ,
   output logic [15:0] ld_cnt,
   output logic [15:0] st_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state;
   logic        op_we;
   logic [1:0]  op_size;
   logic        op_signed;
   logic [1:0]  op_off;
   logic [15:0] op_wdata;

   logic        req_bad;
   logic [32:0] last_byte;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val;
   logic [31:0] merge_val;

   // Last byte of the aligned word must lie inside the backing memory.
   always_comb begin
      last_byte = {1'b0, req_addr[31:2], 2'b11};
      req_bad   = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || (last_byte >= 33'(ADDR_LIMIT));
   end

   always_comb begin
      lane_b    = '0;
      lane_h    = '0;
      load_val  = mem_RD;
      merge_val = mem_RD;
      case (op_off)
         2'd0:    lane_b = mem_RD[31:24];
         2'd1:    lane_b = mem_RD[23:16];
         2'd2:    lane_b = mem_RD[15:8];
         default: lane_b = mem_RD[7:0];
      endcase
      lane_h = op_off[1] ? mem_RD[15:0] : mem_RD[31:16];
      case (op_size)
         2'b00: begin
            load_val = {{24{op_signed & lane_b[7]}}, lane_b};
            case (op_off)
               2'd0:    merge_val[31:24] = op_wdata[7:0];
               2'd1:    merge_val[23:16] = op_wdata[7:0];
               2'd2:    merge_val[15:8]  = op_wdata[7:0];
               default: merge_val[7:0]   = op_wdata[7:0];
            endcase
         end
         2'b01: begin
            load_val = {{16{op_signed & lane_h[15]}}, lane_h};
            if (op_off[1]) merge_val[15:0]  = op_wdata;
            else           merge_val[31:16] = op_wdata;
         end
         default: load_val = mem_RD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_A     <= '0;
         mem_WD    <= '0;
         mem_WE    <= 1'b0;
         op_we     <= 1'b0;
         op_size   <= '0;
         op_signed <= 1'b0;
         op_off    <= '0;
         op_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_we     <= req_we;
                  op_size   <= req_size;
                  op_signed <= req_signed;
                  op_off    <= req_addr[1:0];
                  op_wdata  <= req_wdata[15:0];
                  mem_A     <= {req_addr[31:2], 2'b00};
                  req_ready <= 1'b0;
                  if (req_bad) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end else if (req_we && req_size == 2'b10) begin
                     mem_WD <= req_wdata;
                     mem_WE <= 1'b1;
                     state  <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (op_we) begin
                  mem_WD <= merge_val;
                  mem_WE <= 1'b1;
                  state  <= WRITE;
               end else begin
                  rsp_rdata <= load_val;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            WRITE: begin
               mem_WE    <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            default: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef STAT_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_cnt <= '0;
         st_cnt <= '0;
      end else if (state == RESP && !rsp_err) begin
         if (op_we) st_cnt <= st_cnt + 16'd1;
         else       ld_cnt <= ld_cnt + 16'd1;
      end
   end
`endif

endmodule
